// File: rtl/barrel_rotl_pipe.sv
// Pipelined rotate-left with valid/ready on both sides; stage k rotates by 2^k.
// Restores words that went through the rotate-right shifter with the same amount.

module barrel_rotl_stage #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_vld_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic [SHW-1:0]   up_sh_i,
  input  logic             dn_rdy_i,
  output logic             rdy_o,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   sh_o
);
  localparam int ROT = 1 << K;
  localparam logic [SHW-1:0] ONES = '1;
  // Only the shift bits still to be consumed downstream are carried forward.
  localparam logic [SHW-1:0] KEEP = ONES << (K + 1);

  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] data_d, data_q;
  logic [SHW-1:0]   sh_d, sh_q;
  logic             vld_d, vld_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rot
    assign rot[i] = up_data_i[(i + WIDTH - ROT) % WIDTH];
  end

  assign data_d = up_sh_i[K] ? rot : up_data_i;
  assign sh_d   = up_sh_i & KEEP;
  assign vld_d  = up_vld_i;

  // An empty stage always accepts, which lets bubbles collapse under a stall.
  assign rdy_o = !vld_q || dn_rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
    end else if (rdy_o) begin
      data_q <= data_d;
      sh_q   <= sh_d;
      vld_q  <= vld_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign sh_o   = sh_q;
endmodule

module barrel_rotl_pipe #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [SHW:0]              vld_pipe;
  logic [SHW:0]              rdy;
  logic [SHW:0][WIDTH-1:0]   dat;
  logic [SHW-1:0][SHW-1:0]   sh;

  assign vld_pipe[0] = in_valid;
  assign dat[0]      = in_data;
  assign sh[0]       = in_shift;
  assign rdy[SHW]    = out_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == SHW - 1) begin : g_last
      barrel_rotl_stage #(.WIDTH(WIDTH), .SHW(SHW), .K(k)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_vld_i  (vld_pipe[k]),
        .up_data_i (dat[k]),
        .up_sh_i   (sh[k]),
        .dn_rdy_i  (rdy[k+1]),
        .rdy_o     (rdy[k]),
        .vld_o     (vld_pipe[k+1]),
        .data_o    (dat[k+1]),
        .sh_o      ()
      );
    end else begin : g_mid
      barrel_rotl_stage #(.WIDTH(WIDTH), .SHW(SHW), .K(k)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_vld_i  (vld_pipe[k]),
        .up_data_i (dat[k]),
        .up_sh_i   (sh[k]),
        .dn_rdy_i  (rdy[k+1]),
        .rdy_o     (rdy[k]),
        .vld_o     (vld_pipe[k+1]),
        .data_o    (dat[k+1]),
        .sh_o      (sh[k+1])
      );
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_pipe[SHW];
  assign out_data  = dat[SHW];
endmodule

// File: tb/tb_barrel_rotl_pipe.sv
// Bench for barrel_rotl_pipe: vector table plus scoreboard on the WIDTH=4 unit,
// hand sequences for stall, bubble, reset and a WIDTH=8 spot check.
module tb_barrel_rotl_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_data, out_data;
  logic [1:0] in_shift;
  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] in_data8, out_data8;
  logic [2:0] in_shift8;

  barrel_rotl_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data));

  barrel_rotl_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_shift(in_shift8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8));

  always #5 clk = ~clk;

  typedef struct {logic [3:0] data; logic [1:0] sh; logic [3:0] exp;} vec_t;
  typedef struct {logic [3:0] exp; int cyc;} sb_t;

  vec_t       tab[$];
  sb_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  int         ncyc   = 0;
  logic       lat_chk = 1'b0;
  logic [3:0] cur_exp = '0;

  function automatic logic [3:0] rotr4(input logic [3:0] v, input int s);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[(i + s) % 4];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Scoreboard: transfers are judged at the negedge before the edge that commits them.
  always @(negedge clk) begin
    sb_t e;
    ncyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %b expected none", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.exp) begin
            errors++;
            $display("FAIL out_data: got %b expected %b", out_data, e.exp);
          end
          if (lat_chk && (ncyc - e.cyc) != 2) begin
            errors++;
            $display("FAIL latency: got %0d expected 2", ncyc - e.cyc);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{cur_exp, ncyc});
    end
  end

  task automatic send(input logic [3:0] d, input logic [1:0] s, input logic [3:0] e);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_shift = s; cur_exp = e;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; in_shift8 = '0; out_ready8 = 1'b0;

    // Test 1 vectors, then the full inverse-property sweep.
    tab.push_back('{4'b0001, 2'd0, 4'b0001});
    tab.push_back('{4'b0001, 2'd1, 4'b0010});
    tab.push_back('{4'b0001, 2'd2, 4'b0100});
    tab.push_back('{4'b0001, 2'd3, 4'b1000});
    for (int d = 0; d < 16; d++)
      for (int s = 0; s < 4; s++)
        tab.push_back('{rotr4(4'(d), s), 2'(s), 4'(d)});

    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_rotr_example", 32'(rotr4(4'b1011, 1)), 32'b1101);
    @(posedge clk); #2 rst_n = 1'b1;

    out_ready = 1'b1; lat_chk = 1'b1;
    foreach (tab[i]) send(tab[i].data, tab[i].sh, tab[i].exp);
    idle(); drain();
    lat_chk = 1'b0;

    // Backpressure: A and B fill the pipe, C must wait.
    out_ready = 1'b0;
    send(4'b0011, 2'd1, 4'b0110);
    send(4'b1001, 2'd2, 4'b0110);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 4'b0111; in_shift = 2'd3; cur_exp = 4'b1011;
    @(negedge clk);
    chk("bp_in_ready_0", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_out_data", 32'(out_data), 32'b0110);
    @(negedge clk);
    chk("bp_in_ready_1", 32'(in_ready), 0);
    chk("bp_hold_data", 32'(out_data), 32'b0110);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 1);
    idle(); drain();

    // Bubble collapse: lone word moves to the last stage while stalled.
    out_ready = 1'b0;
    send(4'b1100, 2'd1, 4'b1001);
    idle();
    @(negedge clk); @(negedge clk);
    chk("bub_out_valid", 32'(out_valid), 1);
    chk("bub_out_data", 32'(out_data), 32'b1001);
    chk("bub_in_ready", 32'(in_ready), 1);
    send(4'b0101, 2'd0, 4'b0101);
    idle();
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(4'b1010, 2'd1, 4'b0101);
    send(4'b0110, 2'd2, 4'b1001);
    idle();
    @(negedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_stale", 32'(out_valid), 0);

    // WIDTH=8 spot check: 0x81 rotl 3 = 0x0C after three cycles.
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b1; in_data8 = 8'h81; in_shift8 = 3'd3;
    @(negedge clk);
    chk("w8_in_ready", 32'(in_ready8), 1);
    @(posedge clk); #1 in_valid8 = 1'b0;
    @(negedge clk);
    chk("w8_valid_c1", 32'(out_valid8), 0);
    @(negedge clk);
    chk("w8_valid_c2", 32'(out_valid8), 0);
    @(negedge clk);
    chk("w8_valid_c3", 32'(out_valid8), 1);
    chk("w8_data", 32'(out_data8), 32'h0C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
